// File: rtl/axi_control_m.sv
// AXI4-Lite master: turns single-beat local read/write commands into AW/W/B or AR/R
// transactions, one at a time, and returns data/status on a valid/ready response port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cmd_ready_o high, waiting for a command
// WR      | AW and W valids driven, tracking each channel's handshake
// WR_RESP | bready high, waiting for B
// RD_ADDR | arvalid high, waiting for arready
// RD_DATA | rready high, waiting for R
// RSP     | rsp_valid_o high until the requester takes it
module axi_control_m #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_we_i,
   input  logic [ADDR_W-1:0]   cmd_addr_i,
   input  logic [DATA_W-1:0]   cmd_wdata_i,
   input  logic [DATA_W/8-1:0] cmd_wstrb_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [DATA_W-1:0]   rsp_rdata_o,
   output logic [1:0]          rsp_resp_o,
   output logic                axi_awvalid_o,
   output logic [ADDR_W-1:0]   axi_awaddr_o,
   input  logic                axi_awready_i,
   output logic                axi_wvalid_o,
   output logic [DATA_W-1:0]   axi_wdata_o,
   output logic [DATA_W/8-1:0] axi_wstrb_o,
   input  logic                axi_wready_i,
   input  logic                axi_bvalid_i,
   input  logic [1:0]          axi_bresp_i,
   output logic                axi_bready_o,
   output logic                axi_arvalid_o,
   output logic [ADDR_W-1:0]   axi_araddr_o,
   input  logic                axi_arready_i,
   input  logic                axi_rvalid_i,
   input  logic [DATA_W-1:0]   axi_rdata_i,
   input  logic [1:0]          axi_rresp_i,
   output logic                axi_rready_o
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      WR_RESP = 3'd2,
      RD_ADDR = 3'd3,
      RD_DATA = 3'd4,
      RSP     = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]          rsp_resp_q, rsp_resp_d;
   logic                awvalid_q, awvalid_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
   logic                wvalid_q, wvalid_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic                bready_q, bready_d;
   logic                arvalid_q, arvalid_d;
   logic [ADDR_W-1:0]   araddr_q, araddr_d;
   logic                rready_q, rready_d;
   logic                aw_done_q, aw_done_d;
   logic                w_done_q, w_done_d;

   logic aw_fin, w_fin;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         awvalid_q   <= 1'b0;
         awaddr_q    <= '0;
         wvalid_q    <= 1'b0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         araddr_q    <= '0;
         rready_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
         awvalid_q   <= awvalid_d;
         awaddr_q    <= awaddr_d;
         wvalid_q    <= wvalid_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         araddr_q    <= araddr_d;
         rready_q    <= rready_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
      end
   end

   // A channel counts as finished if it completed earlier or is handshaking now.
   assign aw_fin = aw_done_q | (awvalid_q & axi_awready_i);
   assign w_fin  = w_done_q  | (wvalid_q  & axi_wready_i);

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      awvalid_d   = awvalid_q;
      awaddr_d    = awaddr_q;
      wvalid_d    = wvalid_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      araddr_d    = araddr_q;
      rready_d    = rready_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;

      unique case (state_q)
         IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid_i && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               if (cmd_we_i) begin
                  awaddr_d  = cmd_addr_i;
                  wdata_d   = cmd_wdata_i;
                  wstrb_d   = cmd_wstrb_i;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  state_d   = WR;
               end else begin
                  araddr_d  = cmd_addr_i;
                  arvalid_d = 1'b1;
                  state_d   = RD_ADDR;
               end
            end
         end
         WR: begin
            aw_done_d = aw_fin;
            w_done_d  = w_fin;
            if (aw_fin) awvalid_d = 1'b0;
            if (w_fin)  wvalid_d  = 1'b0;
            if (aw_fin && w_fin) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end
         WR_RESP: begin
            if (axi_bvalid_i && bready_q) begin
               bready_d    = 1'b0;
               rsp_resp_d  = axi_bresp_i;
               rsp_rdata_d = '0;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end
         end
         RD_ADDR: begin
            if (axi_arready_i && arvalid_q) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (axi_rvalid_i && rready_q) begin
               rready_d    = 1'b0;
               rsp_rdata_d = axi_rdata_i;
               rsp_resp_d  = axi_rresp_i;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end
         end
         RSP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cmd_ready_o   = cmd_ready_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rdata_o   = rsp_rdata_q;
   assign rsp_resp_o    = rsp_resp_q;
   assign axi_awvalid_o = awvalid_q;
   assign axi_awaddr_o  = awaddr_q;
   assign axi_wvalid_o  = wvalid_q;
   assign axi_wdata_o   = wdata_q;
   assign axi_wstrb_o   = wstrb_q;
   assign axi_bready_o  = bready_q;
   assign axi_arvalid_o = arvalid_q;
   assign axi_araddr_o  = araddr_q;
   assign axi_rready_o  = rready_q;

endmodule
